// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM region plus a 16-byte MMIO window
// holding an output FIFO, a free-running cycle counter and a fault register.
module dmem_responder #(
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000,
  parameter int unsigned RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] SEL_OUT    = 2'd0;
  localparam logic [1:0] SEL_STATUS = 2'd1;
  localparam logic [1:0] SEL_CYCLE  = 2'd2;
  localparam logic [1:0] SEL_FAULT  = 2'd3;

  logic [31:0]   ram      [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycle_cnt;
  logic [1:0]    fault;

  logic          ram_hit;
  logic          mmio_hit;
  logic          unmapped;
  logic          misaligned;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;

  logic          ram_we;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  logic          cycle_we;
  logic [1:0]    fault_set;
  logic [1:0]    fault_clr;

  // STATUS layout: bit0 full, bit1 empty, bit2 sticky overflow, bits[8:4] count
  function automatic logic [31:0] status_word(input logic [CW-1:0] cnt,
                                              input logic          ovf);
    status_word = {23'b0, 5'(cnt), 1'b0, ovf, (cnt == '0), (cnt == DEPTH_C)};
  endfunction

  // Address decode; RAM base is aligned to its size so a prefix match suffices
  assign ram_hit    = (address[31:AW+2] == RAM_BASE[31:AW+2]);
  assign mmio_hit   = (address[31:4] == MMIO_BASE[31:4]);
  assign unmapped   = !ram_hit && !mmio_hit;
  assign misaligned = |address[1:0];
  assign reg_sel    = address[3:2];
  assign ram_idx    = address[AW+1:2];

  assign ram_we    = write_enable && ram_hit;
  assign cycle_we  = write_enable && mmio_hit && (reg_sel == SEL_CYCLE);
  assign push      = write_enable && mmio_hit && (reg_sel == SEL_OUT);
  assign pop       = out_valid && out_ready;
  // A pop frees the head slot at the same edge, so a full FIFO can still take a push
  assign push_ok   = push && ((count != DEPTH_C) || pop);
  assign push_drop = push && !push_ok;

  // Faults are raised by the address seen in any cycle, read or write
  assign fault_set = {misaligned, unmapped};
  assign fault_clr = (write_enable && mmio_hit && (reg_sel == SEL_FAULT)) ?
                     write_data[1:0] : 2'b00;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 32'h0;

  // Combinational load path: RAM word or MMIO register selected by address
  always_comb begin
    read_data = 32'h0;
    if (ram_hit) begin
      read_data = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        SEL_STATUS: read_data = status_word(count, overflow);
        SEL_CYCLE:  read_data = cycle_cnt;
        SEL_FAULT:  read_data = {30'b0, fault};
        default:    read_data = 32'h0;
      endcase
    end
  end

  // RAM store; contents survive reset
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[ram_idx] <= write_data;
    end
  end

  // FIFO storage; only entries between the pointers are ever observed
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= write_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (!push_ok && pop) begin
        count <= count - CW'(1);
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Free-running cycle counter; a CPU store replaces that cycle's increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'h0;
    end else if (cycle_we) begin
      cycle_cnt <= write_data;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Sticky fault bits, write-one-to-clear; a new fault in the same cycle wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault <= 2'b00;
    end else begin
      fault <= (fault & ~fault_clr) | fault_set;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, FIFO, cycle counter, faults, reset.
module tb_dmem_responder;

  localparam logic [31:0] IDLE   = 32'h1001_0100;
  localparam logic [31:0] A_OUT  = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
  localparam logic [31:0] A_FLT  = 32'hFFFF_000C;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  dmem_responder dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clock = ~clock;

  task automatic set(input logic [31:0] a, input logic [31:0] d, input logic we);
    address      = a;
    write_data   = d;
    write_enable = we;
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    out_ready = 1'b0;
    set(A_CYC, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++; $display("FAIL reset_cycle: got %h want %h", read_data, 32'h0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h want %h", out_data, 32'h0);
    end
    set(A_STAT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h2) begin
      errors++; $display("FAIL reset_status: got %h want %h", read_data, 32'h2);
    end
    set(A_FLT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++; $display("FAIL reset_fault: got %h want %h", read_data, 32'h0);
    end
    set(IDLE, 32'h0, 1'b0);
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic test_ram;
    set(32'h1001_0010, 32'h1111_1111, 1'b1);
    tick;
    set(32'h1001_0014, 32'h2222_2222, 1'b1);
    tick;
    set(32'h1001_0010, 32'hDEAD_BEEF, 1'b1);
    #1;
    checks++;
    if (read_data !== 32'h1111_1111) begin
      errors++; $display("FAIL ram_same_cycle: got %h want %h", read_data, 32'h1111_1111);
    end
    tick;
    set(32'h1001_0010, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_next_cycle: got %h want %h", read_data, 32'hDEAD_BEEF);
    end
    set(32'h1001_0014, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h2222_2222) begin
      errors++; $display("FAIL ram_neighbour: got %h want %h", read_data, 32'h2222_2222);
    end
    set(IDLE, 32'h0, 1'b0);
    tick;
  endtask

  task automatic test_fifo_fill;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      set(A_OUT, 32'(i), 1'b1);
      tick;
    end
    set(A_STAT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h81) begin
      errors++; $display("FAIL fifo_status_full: got %h want %h", read_data, 32'h81);
    end
    set(A_OUT, 32'd9, 1'b1);
    tick;
    set(A_STAT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h85) begin
      errors++; $display("FAIL fifo_status_overflow: got %h want %h", read_data, 32'h85);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++;
        $display("FAIL fifo_drain_%0d: got valid=%b data=%h want valid=1 data=%h",
                 i, out_valid, out_data, 32'(i));
      end
      tick;
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL fifo_drained: got valid=%b data=%h want valid=0 data=0", out_valid, out_data);
    end
    checks++;
    if (read_data !== 32'h06) begin
      errors++; $display("FAIL fifo_status_empty: got %h want %h", read_data, 32'h06);
    end
    set(IDLE, 32'h0, 1'b0);
    tick;
  endtask

  task automatic test_cycle;
    set(A_CYC, 32'hFFFF_FFFE, 1'b1);
    tick;
    set(A_CYC, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL cycle_loaded: got %h want %h", read_data, 32'hFFFF_FFFE);
    end
    tick;
    checks++;
    if (read_data !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL cycle_max: got %h want %h", read_data, 32'hFFFF_FFFF);
    end
    tick;
    checks++;
    if (read_data !== 32'h0) begin
      errors++; $display("FAIL cycle_wrap: got %h want %h", read_data, 32'h0);
    end
    set(IDLE, 32'h0, 1'b0);
    tick;
  endtask

  task automatic test_faults;
    set(A_FLT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++; $display("FAIL fault_clean: got %h want %h", read_data, 32'h0);
    end
    set(32'h0000_0000, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: got %h want %h", read_data, 32'h0);
    end
    tick;
    set(A_FLT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h1) begin
      errors++; $display("FAIL fault_unmapped: got %h want %h", read_data, 32'h1);
    end
    set(32'h1001_0002, 32'h5555_AAAA, 1'b1);
    tick;
    set(A_FLT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h3) begin
      errors++; $display("FAIL fault_misaligned: got %h want %h", read_data, 32'h3);
    end
    set(32'h1001_0000, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h5555_AAAA) begin
      errors++; $display("FAIL misaligned_store: got %h want %h", read_data, 32'h5555_AAAA);
    end
    set(A_FLT, 32'h1, 1'b1);
    tick;
    set(A_FLT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h2) begin
      errors++; $display("FAIL fault_clear: got %h want %h", read_data, 32'h2);
    end
    set(32'hFFFF_000E, 32'h2, 1'b1);
    tick;
    set(A_FLT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h2) begin
      errors++; $display("FAIL fault_set_wins: got %h want %h", read_data, 32'h2);
    end
    set(IDLE, 32'h0, 1'b0);
    tick;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set(A_OUT, 32'h40 + 32'(i), 1'b1);
      tick;
    end
    set(A_CYC, 32'd100, 1'b1);
    tick;
    set(A_CYC, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'd100 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got cycle=%0d valid=%b want cycle=100 valid=1", read_data, out_valid);
    end
    set(A_STAT, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || read_data !== 32'h02) begin
      errors++;
      $display("FAIL async_reset: got valid=%b status=%h want valid=0 status=02", out_valid, read_data);
    end
    #4;
    reset = 1'b1;
    set(A_CYC, 32'h0, 1'b0);
    tick;
    checks++;
    if (read_data !== 32'd1) begin
      errors++; $display("FAIL cycle_restart: got %h want %h", read_data, 32'd1);
    end
    set(A_FLT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      errors++; $display("FAIL fault_after_reset: got %h want %h", read_data, 32'h0);
    end
    set(32'h1001_0010, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_retained: got %h want %h", read_data, 32'hDEAD_BEEF);
    end
    set(IDLE, 32'h0, 1'b0);
    tick;
  endtask

  task automatic test_full_push_pop;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set(A_OUT, 32'h10 + 32'(i), 1'b1);
      tick;
    end
    out_ready = 1'b1;
    set(A_OUT, 32'hAA, 1'b1);
    tick;
    out_ready = 1'b0;
    set(A_STAT, 32'h0, 1'b0);
    #1;
    checks++;
    if (read_data !== 32'h81) begin
      errors++; $display("FAIL full_push_pop_status: got %h want %h", read_data, 32'h81);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] exp;
      exp = (i == 8) ? 32'hAA : 32'h10 + 32'(i);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL full_drain_%0d: got valid=%b data=%h want valid=1 data=%h",
                 i, out_valid, out_data, exp);
      end
      tick;
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL full_drained: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_empty_push_pop;
    out_ready = 1'b1;
    set(A_OUT, 32'h33, 1'b1);
    tick;
    set(A_STAT, 32'h0, 1'b0);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h33 || read_data !== 32'h10) begin
      errors++;
      $display("FAIL empty_push_pop: got valid=%b data=%h status=%h want valid=1 data=33 status=10",
               out_valid, out_data, read_data);
    end
    tick;
    #1;
    checks++;
    if (out_valid !== 1'b0 || read_data !== 32'h02) begin
      errors++;
      $display("FAIL empty_push_pop_drain: got valid=%b status=%h want valid=0 status=02",
               out_valid, read_data);
    end
    out_ready = 1'b0;
    set(IDLE, 32'h0, 1'b0);
    tick;
  endtask

  initial begin
    test_reset;
    test_ram;
    test_fifo_fill;
    test_cycle;
    test_faults;
    test_async_reset;
    test_full_push_pop;
    test_empty_push_pop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
